// File: rtl/intersection_input_conditioner.sv
// Sync, debounce and condition raw sensor/button pins for intersection_controller.
// Sensor drop-outs are stretched; pedestrian requests latch until served.
module intersection_input_conditioner #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned SENSOR_HOLD_MS = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic ns_sensor_raw,
  input  logic ew_sensor_raw,
  input  logic pd_button_ns_raw,
  input  logic pd_button_ew_raw,
  input  logic pd_FREE_NS,
  input  logic pd_FREE_EW,
  output logic ns_sensor,
  output logic ew_sensor,
  output logic pd_button_ns,
  output logic pd_button_ew,
  output logic pd_press_ns,
  output logic pd_press_ew
);

  localparam logic [31:0] DEB_CYC  = 32'(CLK_FREQ / 1000 * DEBOUNCE_MS);
  localparam logic [31:0] HOLD_CYC = 32'(CLK_FREQ / 1000 * SENSOR_HOLD_MS);
  localparam int N = 4;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } deb_state_e;

  logic [N-1:0] raw;
  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;
  logic [N-1:0] lvl_q;
  logic [N-1:0] differ;
  logic [N-1:0] flip;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  deb_state_e   st_q  [N];
  logic [31:0]  cnt_q [N];

  logic [31:0]  hold_q [2];
  logic [1:0]   free;
  logic [1:0]   free_prev_q;
  logic [1:0]   free_rise;
  logic [1:0]   accept;
  logic [1:0]   btn_q;
  logic [1:0]   press_q;

  // channel order: 0 ns sensor, 1 ew sensor, 2 ns button, 3 ew button
  assign raw    = {pd_button_ew_raw, pd_button_ns_raw,
                   ew_sensor_raw, ns_sensor_raw};
  assign differ = sync_q ^ lvl_q;
  assign rise   = flip & ~lvl_q;
  assign fall   = flip & lvl_q;

  always_comb begin
    flip = '0;
    for (int i = 0; i < N; i++) begin
      unique case (st_q[i])
        STABLE_LO, STABLE_HI:
          flip[i] = differ[i] && (DEB_CYC == 32'd1);
        WAIT_HI, WAIT_LO:
          flip[i] = differ[i] && ((cnt_q[i] + 32'd1) >= DEB_CYC);
        default:
          flip[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      lvl_q  <= '0;
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= STABLE_LO;
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      for (int i = 0; i < N; i++) begin
        unique case (st_q[i])
          STABLE_LO, STABLE_HI: begin
            if (flip[i]) begin
              lvl_q[i] <= ~lvl_q[i];
              st_q[i]  <= lvl_q[i] ? STABLE_LO : STABLE_HI;
              cnt_q[i] <= '0;
            end else if (differ[i]) begin
              st_q[i]  <= lvl_q[i] ? WAIT_LO : WAIT_HI;
              cnt_q[i] <= 32'd1;
            end
          end
          WAIT_HI, WAIT_LO: begin
            if (!differ[i]) begin
              st_q[i]  <= lvl_q[i] ? STABLE_HI : STABLE_LO;
              cnt_q[i] <= '0;
            end else if (flip[i]) begin
              lvl_q[i] <= ~lvl_q[i];
              st_q[i]  <= lvl_q[i] ? STABLE_LO : STABLE_HI;
              cnt_q[i] <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 32'd1;
            end
          end
          default: begin
            st_q[i]  <= STABLE_LO;
            cnt_q[i] <= '0;
          end
        endcase
      end
    end
  end

  // hold starts on the same edge the debounced level drops, so no gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q[0] <= '0;
      hold_q[1] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (fall[j])
          hold_q[j] <= HOLD_CYC;
        else if (rise[j])
          hold_q[j] <= '0;
        else if (hold_q[j] != '0)
          hold_q[j] <= hold_q[j] - 32'd1;
      end
    end
  end

  assign free      = {pd_FREE_EW, pd_FREE_NS};
  assign free_rise = free & ~free_prev_q;
  assign accept    = rise[3:2] & ~free & ~free_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_prev_q <= '0;
      btn_q       <= '0;
      press_q     <= '0;
    end else begin
      free_prev_q <= free;
      press_q     <= accept;
      for (int j = 0; j < 2; j++) begin
        if (free_rise[j])
          btn_q[j] <= 1'b0;
        else if (accept[j])
          btn_q[j] <= 1'b1;
      end
    end
  end

  assign ns_sensor    = lvl_q[0] | (hold_q[0] != '0);
  assign ew_sensor    = lvl_q[1] | (hold_q[1] != '0);
  assign pd_button_ns = btn_q[0];
  assign pd_button_ew = btn_q[1];
  assign pd_press_ns  = press_q[0];
  assign pd_press_ew  = press_q[1];

endmodule

// File: tb/tb_intersection_input_conditioner.sv
// Directed bench for intersection_input_conditioner.
// DEB_CYC=3, HOLD_CYC=5; outputs sampled 1 time unit after each posedge.
module tb_intersection_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic ns_r, ew_r, pbns_r, pbew_r;
  logic free_ns, free_ew;
  logic ns_sensor, ew_sensor;
  logic pd_button_ns, pd_button_ew;
  logic pd_press_ns, pd_press_ew;

  always #5 clk = ~clk;

  intersection_input_conditioner #(
    .CLK_FREQ      (1000),
    .DEBOUNCE_MS   (3),
    .SENSOR_HOLD_MS(5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ns_sensor_raw   (ns_r),
    .ew_sensor_raw   (ew_r),
    .pd_button_ns_raw(pbns_r),
    .pd_button_ew_raw(pbew_r),
    .pd_FREE_NS      (free_ns),
    .pd_FREE_EW      (free_ew),
    .ns_sensor       (ns_sensor),
    .ew_sensor       (ew_sensor),
    .pd_button_ns    (pd_button_ns),
    .pd_button_ew    (pd_button_ew),
    .pd_press_ns     (pd_press_ns),
    .pd_press_ew     (pd_press_ew)
  );

  // raw: {ns_s, ew_s, pb_ns, pb_ew}; free: {ns, ew}
  // exp: {ns_sensor, ew_sensor, btn_ns, btn_ew, press_ns, press_ew}
  typedef struct {
    logic [3:0] raw;
    logic [1:0] free;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [5:0] obs();
    return {ns_sensor, ew_sensor, pd_button_ns, pd_button_ew,
            pd_press_ns, pd_press_ew};
  endfunction

  task automatic check(input string name, input logic [5:0] got,
                       input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [1:0] f);
    {ns_r, ew_r, pbns_r, pbew_r} = r;
    {free_ns, free_ew} = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic [1:0] f,
                     input logic [5:0] e, input int n);
    vec_t v;
    v.raw = r;
    v.free = f;
    v.exp = e;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(4'b0000, 2'b00);
    for (int k = 0; k < 2; k++) begin
      step();
      check("reset_low", obs(), 6'b0);
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(4'b1111, 2'b00);

    // glitch shorter than DEB_CYC on ns button
    add(4'b0010, 2'b00, 6'b000000, 2);
    add(4'b0000, 2'b00, 6'b000000, 5);
    // ns press held 10 cycles, then FREE_NS clears the latch
    add(4'b0010, 2'b00, 6'b000000, 4);
    add(4'b0010, 2'b00, 6'b001010, 1);
    add(4'b0010, 2'b00, 6'b001000, 5);
    add(4'b0000, 2'b00, 6'b001000, 8);
    add(4'b0000, 2'b10, 6'b000000, 3);
    add(4'b0000, 2'b00, 6'b000000, 1);
    // ew press, release, press again while latched
    add(4'b0001, 2'b00, 6'b000000, 4);
    add(4'b0001, 2'b00, 6'b000101, 1);
    add(4'b0001, 2'b00, 6'b000100, 1);
    add(4'b0000, 2'b00, 6'b000100, 6);
    add(4'b0001, 2'b00, 6'b000100, 4);
    add(4'b0001, 2'b00, 6'b000101, 1);
    add(4'b0001, 2'b00, 6'b000100, 1);
    add(4'b0000, 2'b00, 6'b000100, 6);
    // FREE_EW: clear, ignored press, press aligned with FREE rise
    add(4'b0000, 2'b01, 6'b000000, 1);
    add(4'b0001, 2'b01, 6'b000000, 6);
    add(4'b0000, 2'b01, 6'b000000, 6);
    add(4'b0000, 2'b00, 6'b000000, 1);
    add(4'b0001, 2'b00, 6'b000000, 4);
    add(4'b0001, 2'b01, 6'b000000, 1);
    add(4'b0001, 2'b01, 6'b000000, 3);
    add(4'b0000, 2'b00, 6'b000000, 6);
    // ew sensor stretch: falls 5+5 after raw fall
    add(4'b0100, 2'b00, 6'b000000, 4);
    add(4'b0100, 2'b00, 6'b010000, 6);
    add(4'b0000, 2'b00, 6'b010000, 9);
    add(4'b0000, 2'b00, 6'b000000, 1);
    // re-raise at the last hold cycle: no gap
    add(4'b0100, 2'b00, 6'b000000, 4);
    add(4'b0100, 2'b00, 6'b010000, 6);
    add(4'b0000, 2'b00, 6'b010000, 5);
    add(4'b0100, 2'b00, 6'b010000, 10);
    add(4'b0000, 2'b00, 6'b010000, 9);
    add(4'b0000, 2'b00, 6'b000000, 3);

    // reset with all raw pins high, then release
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_allhigh", obs(), 6'b0);
    end
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("rel_wait%0d", k), obs(), 6'b0);
    end
    step();
    check("rel_rise", obs(), 6'b111111);
    step();
    check("rel_after", obs(), 6'b111100);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].raw, tbl[i].free);
      step();
      check($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // async reset mid-hold and mid-debounce
    drive(4'b0100, 2'b00);
    repeat (6) step();
    check("pre_hold_hi", obs(), 6'b010000);
    drive(4'b0000, 2'b00);
    repeat (6) step();
    check("in_hold", obs(), 6'b010000);
    drive(4'b0010, 2'b00);
    repeat (3) step();
    check("mid_deb", obs(), 6'b010000);
    #3 rst = 1'b0;
    #1 check("async_rst", obs(), 6'b0);
    drive(4'b0000, 2'b00);
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_held", obs(), 6'b0);
    end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("no_stale%0d", k), obs(), 6'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
